run_mode_controller: RTL
========================

Name: run_mode_controller

Overview:
- Sequences JPEG-LS run mode between the mode decision and the run-interruption coder.
- Consumes pixels that are in run mode; compares each x against run value a (within NEAR) and counts the run.
- Emits run-segment/tail/interruption code tokens using the J[RUNindex] table, maintaining RUNindex across the scan.
- Forwards the interrupting pixel with its RUNindex.

Parameters:
pixel_length, 8, pixel sample width
runcount_length, 16, run counter width (holds up to 2^15)
runindex_length, 5, RUNindex width (0..31)
near, 0, NEAR tolerance for run match

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-low reset
start_enc  input  1  synchronous pulse at scan start: clears RUNindex/count, enters ACTIVE
in_valid  input  1  pixel valid
in_ready  output  1  pixel accepted when in_valid && in_ready
in_x  input  pixel_length  current sample
in_a  input  pixel_length  run value (Ra)
in_eol  input  1  pixel is last of line
out_valid  output  1  token valid
out_ready  input  1  token consumed when out_valid && out_ready
out_kind  output  2  00 segment, 01 EOL tail, 10 interruption
out_value  output  16  code bits, LSB-aligned, MSB sent first
out_len  output  5  code length 1..16
out_x  output  pixel_length  interrupting sample (kind 10; else 0)
out_a  output  pixel_length  run value at interruption (kind 10; else 0)
out_runindex  output  runindex_length  RUNindex before update
run_count  output  runcount_length  current count (status)
run_index  output  runindex_length  current RUNindex (status)

Behaviour:
- Reset (async, reset=0): state IDLE; count=0, RUNindex=0, out_valid=0, all out_* = 0, in_ready=0.
- States: IDLE -> ACTIVE on start_enc. In ACTIVE, start_enc clears count, RUNindex and out_valid (drops any pending token); it has priority over accept, and in_ready=0 that cycle. No exit from ACTIVE except reset.
- in_ready = ACTIVE && !start_enc && (!out_valid || out_ready).
- J table (index 0..31): 0,0,0,0,1,1,1,1,2,2,2,2,3,3,3,3,4,4,5,5,6,6,7,7,8,9,10,11,12,13,14,15. rg = 1<<J[RUNindex].
- Match: |in_x - in_a| <= near, computed unsigned without wrap.
- On accept, with c = count+1:
  - Match, c == rg: token kind 00, value 1, len 1; count<=0; RUNindex<=min(RUNindex+1,31). Applies even with eol; no tail follows.
  - Match, c < rg, eol: token kind 01, value 1, len 1; count<=0; RUNindex unchanged.
  - Match, c < rg, !eol: count<=c; no token.
  - Mismatch (eol irrelevant): token kind 10, len J+1, value = {1'b0, count[J-1:0]}; out_x/out_a = pixel; out_runindex = RUNindex; count<=0; RUNindex<=RUNindex-1 if >0, else stays 0.
- Token registered: out_valid rises the cycle after accept and is held with all out_* stable until out_ready. Back-to-back tokens at one per cycle are allowed when out_ready stays high.
- out_runindex is the pre-update value for every kind.

Test Plan:
1. Reset, start_enc, 3 pixels x=a=100, no eol -> three kind-00 tokens (value 1, len 1), out_runindex 0,1,2; run_index ends at 3.
2. From run_index 4 (J=1, rg=2): one match, then x=50, a=100 -> kind 10, len 2, value 2'b01, out_x=50, out_a=100, out_runindex 4; run_index becomes 3, count 0.
3. From run_index 4: one match with in_eol=1 -> kind 01, value 1, len 1; run_index stays 4, count 0. Then a mismatch at run_index 0 -> kind 10, len 1, value 0; run_index stays 0.
4. near=2: x=102, a=100 counts as a match; x=103, a=100 gives an interruption token.
5. Backpressure: token pending with out_ready=0 for 3 cycles -> in_ready=0 and out_* stable. out_ready=1 -> token consumed, next pixel accepted the same cycle.
6. Assert reset mid-run with count=1, run_index=5 and out_valid=1 -> outputs go to 0 immediately, in_ready=0 until start_enc. After start_enc, run_index=0.

Source files
------------

// File: rtl/run_mode_controller.sv
// JPEG-LS run-mode controller: counts pixels matching the run value and emits
// run-segment, end-of-line tail and interruption tokens, tracking RUNindex.
module run_mode_controller #(
    parameter int unsigned pixel_length    = 8,
    parameter int unsigned runcount_length = 16,
    parameter int unsigned runindex_length = 5,
    parameter int unsigned near            = 0
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start_enc,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [pixel_length-1:0]    in_x,
    input  logic [pixel_length-1:0]    in_a,
    input  logic                       in_eol,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [1:0]                 out_kind,
    output logic [15:0]                out_value,
    output logic [4:0]                 out_len,
    output logic [pixel_length-1:0]    out_x,
    output logic [pixel_length-1:0]    out_a,
    output logic [runindex_length-1:0] out_runindex,
    output logic [runcount_length-1:0] run_count,
    output logic [runindex_length-1:0] run_index
);

    localparam int unsigned CW = runcount_length + 1;

    typedef enum logic [0:0] {StIdle, StActive} state_e;

    // J[RUNindex]: run-length order per RUNindex
    function automatic logic [3:0] j_of(input logic [4:0] idx);
        logic [3:0] j;
        if (idx < 5'd16) begin
            j = 4'(idx >> 2);
        end else if (idx < 5'd24) begin
            j = 4'(4 + ((idx - 5'd16) >> 1));
        end else begin
            j = 4'(idx - 5'd16);
        end
        return j;
    endfunction

    state_e                      state_q, state_d;
    logic [runcount_length-1:0]  count_q, count_d;
    logic [runindex_length-1:0]  runindex_q, runindex_d;
    logic                        out_valid_q, out_valid_d;
    logic [1:0]                  out_kind_q, out_kind_d;
    logic [15:0]                 out_value_q, out_value_d;
    logic [4:0]                  out_len_q, out_len_d;
    logic [pixel_length-1:0]     out_x_q, out_x_d;
    logic [pixel_length-1:0]     out_a_q, out_a_d;
    logic [runindex_length-1:0]  out_runindex_q, out_runindex_d;

    logic [3:0]              j;
    logic [CW-1:0]           rg;
    logic [CW-1:0]           c_ext;
    logic [pixel_length-1:0] diff;
    logic                    match;
    logic [15:0]             seg_mask;
    logic                    accept;

    // Datapath: run limit, incremented count and |x - a| match test
    always_comb begin
        j        = j_of(5'(runindex_q));
        rg       = CW'(1) << j;
        c_ext    = {1'b0, count_q} + CW'(1);
        diff     = (in_x >= in_a) ? (in_x - in_a) : (in_a - in_x);
        match    = (32'(diff) <= near);
        seg_mask = (16'(1) << j) - 16'd1;
        in_ready = (state_q == StActive) && !start_enc && (!out_valid_q || out_ready);
        accept   = in_valid && in_ready;
    end

    // Next-state: scan restart, run counting and token generation
    always_comb begin
        state_d        = state_q;
        count_d        = count_q;
        runindex_d     = runindex_q;
        out_valid_d    = out_valid_q && !out_ready;
        out_kind_d     = out_kind_q;
        out_value_d    = out_value_q;
        out_len_d      = out_len_q;
        out_x_d        = out_x_q;
        out_a_d        = out_a_q;
        out_runindex_d = out_runindex_q;

        if (start_enc) begin
            // Restart drops any pending token
            state_d     = StActive;
            count_d     = '0;
            runindex_d  = '0;
            out_valid_d = 1'b0;
        end else if (accept) begin
            if (match && (c_ext != rg) && !in_eol) begin
                count_d = count_q + runcount_length'(1);
            end else begin
                out_valid_d    = 1'b1;
                out_runindex_d = runindex_q;
                out_x_d        = '0;
                out_a_d        = '0;
                out_value_d    = 16'd1;
                out_len_d      = 5'd1;
                count_d        = '0;
                if (match && (c_ext == rg)) begin
                    out_kind_d = 2'b00;
                    if (runindex_q != '1) begin
                        runindex_d = runindex_q + runindex_length'(1);
                    end
                end else if (match) begin
                    out_kind_d = 2'b01;
                end else begin
                    // Interruption: J-bit count remainder behind a leading 0
                    out_kind_d  = 2'b10;
                    out_value_d = 16'(count_q) & seg_mask;
                    out_len_d   = {1'b0, j} + 5'd1;
                    out_x_d     = in_x;
                    out_a_d     = in_a;
                    if (runindex_q != '0) begin
                        runindex_d = runindex_q - runindex_length'(1);
                    end
                end
            end
        end
    end

    // State and token registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= StIdle;
            count_q        <= '0;
            runindex_q     <= '0;
            out_valid_q    <= 1'b0;
            out_kind_q     <= '0;
            out_value_q    <= '0;
            out_len_q      <= '0;
            out_x_q        <= '0;
            out_a_q        <= '0;
            out_runindex_q <= '0;
        end else begin
            state_q        <= state_d;
            count_q        <= count_d;
            runindex_q     <= runindex_d;
            out_valid_q    <= out_valid_d;
            out_kind_q     <= out_kind_d;
            out_value_q    <= out_value_d;
            out_len_q      <= out_len_d;
            out_x_q        <= out_x_d;
            out_a_q        <= out_a_d;
            out_runindex_q <= out_runindex_d;
        end
    end

    assign out_valid    = out_valid_q;
    assign out_kind     = out_kind_q;
    assign out_value    = out_value_q;
    assign out_len      = out_len_q;
    assign out_x        = out_x_q;
    assign out_a        = out_a_q;
    assign out_runindex = out_runindex_q;
    assign run_count    = count_q;
    assign run_index    = runindex_q;

endmodule
